// File: rtl/ysyx_22041461_wbu_pkg.sv
// Shared constants for the write-back stage: datapath width, register count
// and the write-back source select encoding.
package ysyx_22041461_pkg;

    localparam int XLEN    = 64;
    localparam int NR_REGS = 32;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_SNPC = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;

    localparam logic [4:0] A0_IDX = 5'd10;

endpackage

// File: rtl/ysyx_22041461_wbu_if.sv
// MEM -> WB retirement bus: valid/ready handshake plus the retiring
// instruction's fields.
interface ysyx_22041461_wbu_if;
    import ysyx_22041461_pkg::*;

    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic            wen;
    logic [1:0]      sel_wb;
    logic [XLEN-1:0] dest;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] snpc;
    logic            ebreak;

    modport master (
        output valid, pc, inst, rd, wen, sel_wb, dest, read_data, snpc, ebreak,
        input  ready
    );

    modport slave (
        input  valid, pc, inst, rd, wen, sel_wb, dest, read_data, snpc, ebreak,
        output ready
    );

endinterface

// File: rtl/ysyx_22041461_wbu_regfile.sv
// 32x64 integer register file: one synchronous write port, two asynchronous
// read ports plus a dedicated a0 tap for the halt exit code; x0 reads as zero.
module ysyx_22041461_regfile
    import ysyx_22041461_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    output logic [XLEN-1:0] a0_o
);

    logic [XLEN-1:0] regs_q [NR_REGS];

    // NOTE: the architectural state must read zero after reset, so the whole
    // array is cleared here; this rules out a plain RAM macro for the storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            // NOTE: sequential state is always assigned non-blocking so every
            // reader sees the pre-edge value regardless of block ordering.
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];
    assign a0_o     = regs_q[A0_IDX];

endmodule

// File: rtl/ysyx_22041461_wbu.sv
// Write-back stage: MEM/WB register, write-back mux, regfile write, decode read
// ports and sticky ebreak halt. Define WBU_BYPASS_EN to forward the pending write.
module ysyx_22041461_wbu
    import ysyx_22041461_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22041461_wbu_if.slave       mem_in,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [XLEN-1:0]          rs1_data,
    output logic [XLEN-1:0]          rs2_data,
    output logic                     commit_valid,
    output logic [XLEN-1:0]          commit_pc,
    output logic [31:0]              commit_inst,
    output logic                     halt,
    output logic [XLEN-1:0]          halt_code
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic            ebreak_q;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] halt_code_q, halt_code_d;

    logic            fire;
    logic            rf_we;
    logic            retire_ebreak;
    logic [XLEN-1:0] rf_rs1, rf_rs2, rf_a0, a0_val;

    assign mem_in.ready  = ~halt_q;
    assign fire          = mem_in.valid && mem_in.ready;
    assign retire_ebreak = valid_q && ebreak_q;
    // ebreak never writes back, even with wen set
    assign rf_we         = valid_q && wen_q && !ebreak_q && (rd_q != 5'd0);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        wb_data_d = '0;
        case (mem_in.sel_wb)
            WB_SEL_ALU:  wb_data_d = mem_in.dest;
            WB_SEL_MEM:  wb_data_d = mem_in.read_data;
            WB_SEL_SNPC: wb_data_d = mem_in.snpc;
            default:     wb_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            ebreak_q  <= 1'b0;
            wb_data_q <= '0;
        end else begin
            valid_q <= fire;
            if (fire) begin
                pc_q      <= mem_in.pc;
                inst_q    <= mem_in.inst;
                rd_q      <= mem_in.rd;
                wen_q     <= mem_in.wen;
                ebreak_q  <= mem_in.ebreak;
                wb_data_q <= wb_data_d;
            end
        end
    end

    ysyx_22041461_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (rf_we),
        .waddr_i  (rd_q),
        .wdata_i  (wb_data_q),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rf_rs1),
        .rdata2_o (rf_rs2),
        .a0_o     (rf_a0)
    );

`ifdef WBU_BYPASS_EN
    assign rs1_data = (rf_we && (rd_q == rs1_addr)) ? wb_data_q : rf_rs1;
    assign rs2_data = (rf_we && (rd_q == rs2_addr)) ? wb_data_q : rf_rs2;
    assign a0_val   = (rf_we && (rd_q == A0_IDX))   ? wb_data_q : rf_a0;
`else
    assign rs1_data = rf_rs1;
    assign rs2_data = rf_rs2;
    assign a0_val   = rf_a0;
`endif

    always_comb begin
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        if (retire_ebreak && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = a0_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
        end
    end

    assign commit_valid = valid_q;
    assign commit_pc    = pc_q;
    assign commit_inst  = inst_q;
    assign halt         = halt_q;
    assign halt_code    = halt_code_q;

endmodule

// File: tb/tb_ysyx_22041461_wbu.sv
// Directed self-checking bench for the write-back stage; expected values are
// hand-computed constants.
module tb_ysyx_22041461_wbu;
    import ysyx_22041461_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_inst;
    logic            halt;
    logic [XLEN-1:0] halt_code;

    int tests = 0;
    int fails = 0;

    ysyx_22041461_wbu_if bus ();

    ysyx_22041461_wbu dut (
        .clk          (clk),
        .rst          (rst),
        .mem_in       (bus.slave),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .halt         (halt),
        .halt_code    (halt_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.valid     = 1'b0;
        bus.pc        = '0;
        bus.inst      = '0;
        bus.rd        = '0;
        bus.wen       = 1'b0;
        bus.sel_wb    = WB_SEL_ALU;
        bus.dest      = '0;
        bus.read_data = '0;
        bus.snpc      = '0;
        bus.ebreak    = 1'b0;
    endtask

    // Present one instruction for exactly one edge, then drop valid.
    task automatic fire_one(input logic [63:0] pc, input logic [31:0] inst,
                            input logic [4:0] rd, input logic wen,
                            input logic [1:0] sel, input logic [63:0] dest,
                            input logic [63:0] rdata, input logic [63:0] snpc,
                            input logic ebreak);
        bus.valid     = 1'b1;
        bus.pc        = pc;
        bus.inst      = inst;
        bus.rd        = rd;
        bus.wen       = wen;
        bus.sel_wb    = sel;
        bus.dest      = dest;
        bus.read_data = rdata;
        bus.snpc      = snpc;
        bus.ebreak    = ebreak;
        tick();
        idle_bus();
    endtask

    task automatic read1(input logic [4:0] a, input logic [63:0] exp, input string name);
        rs1_addr = a;
        #1;
        tests++;
        if (rs1_data !== exp) begin
            fails++;
            $display("FAIL %s: rs1_data(x%0d) got %h expected %h", name, a, rs1_data, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        rs1_addr = '0;
        rs2_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        read1(5'd5, 64'h0, "reset_x5");
        tests++;
        if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt: got %b expected 0", halt); end
        tests++;
        if (bus.ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        tests++;
        if (commit_valid !== 1'b0) begin fails++; $display("FAIL reset_commit_valid: got %b expected 0", commit_valid); end
    endtask

    task automatic test_alu_write();
        fire_one(64'h8000_0000, 32'h0000_0293, 5'd5, 1'b1, WB_SEL_ALU, 64'h1234, 64'h0, 64'h0, 1'b0);
        tests++;
        if (commit_valid !== 1'b1) begin fails++; $display("FAIL alu_commit_valid: got %b expected 1", commit_valid); end
        tests++;
        if (commit_pc !== 64'h8000_0000) begin fails++; $display("FAIL alu_commit_pc: got %h expected 8000_0000", commit_pc); end
        tests++;
        if (commit_inst !== 32'h0000_0293) begin fails++; $display("FAIL alu_commit_inst: got %h expected 00000293", commit_inst); end
`ifdef WBU_BYPASS_EN
        read1(5'd5, 64'h1234, "alu_x5_commit_cycle");
`else
        read1(5'd5, 64'h0, "alu_x5_commit_cycle");
`endif
        tick();
        read1(5'd5, 64'h1234, "alu_x5_written");
        tests++;
        if (commit_valid !== 1'b0) begin fails++; $display("FAIL alu_commit_drop: got %b expected 0", commit_valid); end
    endtask

    task automatic test_x0_and_reserved();
        fire_one(64'h8000_0004, 32'h0, 5'd0, 1'b1, WB_SEL_ALU, 64'hFFFF, 64'h0, 64'h0, 1'b0);
        read1(5'd0, 64'h0, "x0_commit_cycle");
        tick();
        read1(5'd0, 64'h0, "x0_after_write");
        fire_one(64'h8000_0008, 32'h0, 5'd7, 1'b1, WB_SEL_ALU, 64'h77, 64'h0, 64'h0, 1'b0);
        tick();
        read1(5'd7, 64'h77, "x7_preload");
        fire_one(64'h8000_000C, 32'h0, 5'd7, 1'b1, WB_SEL_NONE, 64'h55, 64'h66, 64'h88, 1'b0);
        tick();
        read1(5'd7, 64'h0, "x7_reserved_sel");
        fire_one(64'h8000_0010, 32'h0, 5'd1, 1'b1, WB_SEL_SNPC, 64'h55, 64'h66, 64'h8000_0014, 1'b0);
        tick();
        read1(5'd1, 64'h8000_0014, "x1_link");
    endtask

    task automatic test_load_bypass();
        fire_one(64'h8000_0020, 32'h0, 5'd9, 1'b1, WB_SEL_ALU, 64'h1111, 64'h0, 64'h0, 1'b0);
        tick();
        fire_one(64'h8000_0024, 32'h0, 5'd9, 1'b1, WB_SEL_MEM, 64'hBAD, 64'hDEAD, 64'h0, 1'b0);
        rs2_addr = 5'd9;
        #1;
        tests++;
`ifdef WBU_BYPASS_EN
        if (rs2_data !== 64'hDEAD) begin fails++; $display("FAIL load_rs2_commit_cycle: got %h expected dead", rs2_data); end
`else
        if (rs2_data !== 64'h1111) begin fails++; $display("FAIL load_rs2_commit_cycle: got %h expected 1111", rs2_data); end
`endif
        tick();
        tests++;
        if (rs2_data !== 64'hDEAD) begin fails++; $display("FAIL load_rs2_written: got %h expected dead", rs2_data); end
        bus.rd = 5'd9; bus.wen = 1'b1; bus.sel_wb = WB_SEL_MEM; bus.read_data = 64'hBEEF;
        tick();
        tick();
        idle_bus();
        tests++;
        if (rs2_data !== 64'hDEAD) begin fails++; $display("FAIL load_no_valid: got %h expected dead", rs2_data); end
    endtask

    task automatic test_back_to_back();
        bus.valid = 1'b1; bus.rd = 5'd11; bus.wen = 1'b1; bus.sel_wb = WB_SEL_ALU; bus.dest = 64'hA;
        tick();
        bus.rd = 5'd12; bus.dest = 64'hB;
        tick();
        idle_bus();
        tick();
        read1(5'd11, 64'hA, "b2b_x11");
        read1(5'd12, 64'hB, "b2b_x12");
    endtask

    task automatic test_halt();
        fire_one(64'h8000_0030, 32'h0, A0_IDX, 1'b1, WB_SEL_ALU, 64'h2A, 64'h0, 64'h0, 1'b0);
        tick();
        fire_one(64'h8000_0034, 32'h0010_0073, A0_IDX, 1'b1, WB_SEL_ALU, 64'h99, 64'h0, 64'h0, 1'b1);
        tests++;
        if (halt !== 1'b0) begin fails++; $display("FAIL halt_early: got %b expected 0", halt); end
        tick();
        tests++;
        if (halt !== 1'b1) begin fails++; $display("FAIL halt_set: got %b expected 1", halt); end
        tests++;
        if (halt_code !== 64'h2A) begin fails++; $display("FAIL halt_code: got %h expected 2a", halt_code); end
        tests++;
        if (bus.ready !== 1'b0) begin fails++; $display("FAIL halt_ready: got %b expected 0", bus.ready); end
        read1(A0_IDX, 64'h2A, "halt_x10_kept");
        bus.valid = 1'b1; bus.rd = 5'd5; bus.wen = 1'b1; bus.sel_wb = WB_SEL_ALU; bus.dest = 64'h5555;
        tick();
        tests++;
        if (commit_valid !== 1'b0) begin fails++; $display("FAIL halt_no_commit: got %b expected 0", commit_valid); end
        tick();
        tick();
        idle_bus();
        read1(5'd5, 64'h1234, "halt_x5_kept");
        tests++;
        if (halt !== 1'b1) begin fails++; $display("FAIL halt_sticky: got %b expected 1", halt); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (halt !== 1'b0 || halt_code !== 64'h0) begin
            fails++; $display("FAIL halt_cleared: got halt=%b code=%h expected 0/0", halt, halt_code);
        end
        tests++;
        if (bus.ready !== 1'b1) begin fails++; $display("FAIL halt_ready_restored: got %b expected 1", bus.ready); end
        read1(5'd5, 64'h0, "rst_clears_x5");
    endtask

    task automatic test_reset_flush();
        fire_one(64'h8000_0040, 32'h0, 5'd3, 1'b1, WB_SEL_ALU, 64'h3333, 64'h0, 64'h0, 1'b0);
        tests++;
        if (commit_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_valid: got %b expected 1", commit_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (commit_valid !== 1'b0) begin fails++; $display("FAIL flush_commit_valid: got %b expected 0", commit_valid); end
        tick();
        tick();
        read1(5'd3, 64'h0, "flush_x3");
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_x0_and_reserved();
        test_load_bypass();
        test_back_to_back();
        test_halt();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
